// File: rtl/seq_det_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : seq_det_pkg                                                |
// | Description : Shared types and defaults for the parametrised serial      |
// |               sequence detector: FSM state encoding, reset-time          |
// |               pattern/length/overlap defaults and the helper that sizes  |
// |               length/fill fields.                                        |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package seq_det_pkg;

  // Detector FSM: FILL while history is too short to hold a full pattern,
  // DETECT once the next accepted bit can complete one.
  typedef enum logic {
    FILL   = 1'b0,
    DETECT = 1'b1
  } state_t;

  localparam int         PKG_MAX_LEN = 8;
  localparam logic [7:0] PKG_DEF_PAT = 8'b0000_0101;  // 0,1,0,1 (MSB first)
  localparam int         PKG_DEF_LEN = 4;
  localparam bit         PKG_DEF_OVL = 1'b1;

  // Width able to hold any length in 0..max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int PKG_LEN_W = len_width(PKG_MAX_LEN);

endpackage
`default_nettype wire

// File: rtl/seq_detector_param_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sat_counter                                                |
// | Description : Up-counter that holds at its maximum value. Shared by the  |
// |               detector match counter and other status counters.          |
// | Ports       : clk   - clock                                              |
// |               reset - synchronous active-high reset (count -> 0)         |
// |               inc   - increment request                                  |
// |               clr   - synchronous clear, wins over inc                   |
// |               count - current count                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_detector_param                                         |
// | Description : Serial bit-pattern detector with runtime-loadable pattern, |
// |               length (1..MAX_LEN) and overlap mode. Gives a same-cycle   |
// |               Mealy match, a registered match and a saturating count.    |
// | Ports       : clk, reset     - clock, synchronous active-high reset      |
// |               din, din_valid - qualified serial input bit                |
// |               clear          - flush history, keep config and count      |
// |               cfg_load, cfg_pat, cfg_len, cfg_ovl - configuration load   |
// |               cfg_err        - one-cycle pulse after a rejected load     |
// |               match, match_q - combinational / registered match          |
// |               match_count    - saturating match count                    |
// |               state_o        - 0 = FILL, 1 = DETECT                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN = PKG_MAX_LEN,
  parameter int                 CNT_W   = 16,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(PKG_DEF_PAT),
  parameter int                 DEF_LEN = PKG_DEF_LEN,
  parameter bit                 DEF_OVL = PKG_DEF_OVL,
  localparam int                LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               clear,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  output logic               cfg_err,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_count,
  output logic               state_o
);

  state_t             state_q, state_n;
  logic [MAX_LEN-1:0] hist_q, hist_n;
  logic [MAX_LEN-1:0] pat_q, pat_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [LEN_W-1:0]   fill_q, fill_n;
  logic               ovl_q, ovl_n;
  logic               cfg_err_n;
  logic               cfg_ok;
  logic               cnt_clr;
  logic [MAX_LEN-1:0] word;
  logic [MAX_LEN-1:0] mask;

  assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  // Candidate window: stored history with the current bit appended. Only the
  // low len bits take part, so len=1 reduces to comparing din alone.
  assign word = {hist_q[MAX_LEN-2:0], din};
  assign mask = {MAX_LEN{1'b1}} >> (LEN_W'(MAX_LEN) - len_q);

  always_comb begin
    hist_n    = hist_q;
    fill_n    = fill_q;
    pat_n     = pat_q;
    len_n     = len_q;
    ovl_n     = ovl_q;
    cfg_err_n = 1'b0;
    cnt_clr   = 1'b0;
    match     = 1'b0;

    if (cfg_load) begin
      if (cfg_ok) begin
        pat_n   = cfg_pat;
        len_n   = cfg_len;
        ovl_n   = cfg_ovl;
        hist_n  = '0;
        fill_n  = '0;
        cnt_clr = 1'b1;
      end else begin
        cfg_err_n = 1'b1;
      end
    end else if (clear) begin
      hist_n = '0;
      fill_n = '0;
    end else if (din_valid) begin
      match  = (state_q == DETECT) && (((word ^ pat_q) & mask) == '0);
      hist_n = word;
      if (match && !ovl_q) begin
        // Non-overlapping: bits consumed by this match are never reused.
        fill_n = '0;
      end else if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_n = fill_q + LEN_W'(1);
      end
    end

    if (reset) begin
      match = 1'b0;
    end

    // len is never 0 here (reset default and accepted loads are >= 1).
    state_n = (fill_n >= (len_n - LEN_W'(1))) ? DETECT : FILL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PAT;
      len_q   <= LEN_W'(DEF_LEN);
      ovl_q   <= DEF_OVL;
      cfg_err <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_n;
      hist_q  <= hist_n;
      fill_q  <= fill_n;
      pat_q   <= pat_n;
      len_q   <= len_n;
      ovl_q   <= ovl_n;
      cfg_err <= cfg_err_n;
      match_q <= match;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .clr  (cnt_clr),
    .count(match_count)
  );

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector: the generalised successor of the fixed 4-bit Mealy sequence detector.
- Pattern (1..MAX_LEN bits), length and overlap mode are runtime-loadable.
- Provides a Mealy (same-cycle) match flag, a registered match flag and a saturating match counter.
- Sits on a qualified serial bit stream (din/din_valid) between a deserialiser front-end and control/status logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 16, width of the match counter.
- DEF_PAT, 8'b0000_0101, pattern loaded at reset (LSB-aligned, MAX_LEN bits).
- DEF_LEN, 4, pattern length loaded at reset.
- DEF_OVL, 1, overlap mode at reset (1 = overlapping, 0 = non-overlapping).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled only when high.
- clear  in  1  flush history; configuration is kept.
- cfg_load  in  1  load cfg_pat/cfg_len/cfg_ovl.
- cfg_pat  in  MAX_LEN  new pattern, LSB-aligned; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  $clog2(MAX_LEN+1)  new length.
- cfg_ovl  in  1  new overlap mode.
- cfg_err  out  1  one-cycle pulse: load rejected.
- match  out  1  combinational Mealy match for the current din.
- match_q  out  1  match registered (1-cycle latency).
- match_count  out  CNT_W  saturating count of matches.
- state_o  out  1  0 = FILL, 1 = DETECT.

Behaviour:
- Reset: hist=0, fill=0, pat/len/ovl=DEF_*, match_count=0, match_q=0, cfg_err=0, state FILL. Reset is checked before all other inputs.
- Reset configuration detects the sequence 0,1,0,1 with overlap.
- hist is a MAX_LEN shift register. On an accepted bit: hist <= {hist[MAX_LEN-2:0], din}.
- fill counts valid history bits and saturates at MAX_LEN.
- FSM:
  - FILL while fill < len-1.
  - DETECT while fill >= len-1.
  - Transitions follow fill after each update.
- match = din_valid & ~clear & ~cfg_load & (state==DETECT) & ({hist[len-2:0],din} == pat[len-1:0]). Compare only the low len bits; for len=1, compare din only.
- Overlap mode, on an accepted bit: fill <= min(fill+1, MAX_LEN).
- Non-overlap mode, on a matched bit: fill <= 0 and the FSM returns to FILL. Matching bits are never reused.
- din_valid low: no shift, fill unchanged, match=0.
- match_q <= match every cycle.
- match_count increments on match and holds at 2^CNT_W-1.
- clear: hist<=0, fill<=0, FSM to FILL; the din of that cycle is discarded. Count and config are kept.
- cfg_load with 1 <= cfg_len <= MAX_LEN:
  - config updated, history flushed as for clear, count cleared.
  - din of that cycle is discarded.
  - the new config is used from the next cycle.
- cfg_load with cfg_len==0 or cfg_len>MAX_LEN:
  - cfg_err=1 for 1 cycle.
  - config, history and count unchanged; the din of that cycle is discarded.
- Priority: reset > cfg_load > clear > din_valid.
- Reset mid-pattern: partial history is lost, DEF config is restored, no match in that cycle.

Decomposition:
- Shared package seq_det_pkg:
  - FSM state constants (FILL, DETECT).
  - DEF_PAT/DEF_LEN/DEF_OVL defaults.
  - length-width helper constant.
- One sub-module: sat_counter (width CNT_W, inc, clr, sync reset, holds at max). It is reused elsewhere for status counters.

Test Plan:
- After reset, bits 0,1,0,1,0,1 (all valid) -> match high on bits 4 and 6; match_q one cycle later; match_count=2.
- Load ovl=0 (pat 0101, len 4), bits 0,1,0,1,0,1,0,1 -> match on bits 4 and 8 only; count=2.
- Load pat=3'b110, len=3, then bits 1,1,1,0 -> match on bit 4 only.
- Same pattern with din_valid low for 3 cycles between each bit -> same single match.
- Load cfg_len=0 -> cfg_err pulses 1 cycle; the 0101 stream still matches, proving config unchanged.
- Bits 0,1,0, assert clear, then bit 1 -> no match; state_o=FILL after clear.
- CNT_W=4: 20 matches -> match_count stops at 15.
- Reset asserted together with cfg_load -> DEF config active, cfg_err=0.
